// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the Mini-RISC-V decode/control stage.
// Control bundle, FSM states, opcodes, operation selects, trap causes.
package ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    TRAP    = 2'd2
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // mulsel: 1 MUL, 2 MULH, 3 MULHSU, 4 MULHU
  // divsel: 1 DIV, 2 DIVU, 3 REM, 4 REMU
  localparam logic [2:0] MD_NONE = 3'd0;

  localparam logic [2:0] CMP_NONE = 3'd0;
  localparam logic [2:0] CMP_EQ   = 3'd1;
  localparam logic [2:0] CMP_NE   = 3'd2;
  localparam logic [2:0] CMP_LT   = 3'd3;
  localparam logic [2:0] CMP_GE   = 3'd4;
  localparam logic [2:0] CMP_LTU  = 3'd5;
  localparam logic [2:0] CMP_GEU  = 3'd6;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_OPC   = 2'b01;
  localparam logic [1:0] CAUSE_FUNCT = 2'b10;
  localparam logic [1:0] CAUSE_DIS   = 2'b11;

  typedef struct packed {
    logic [3:0] alusel;
    logic [2:0] mulsel;
    logic [2:0] divsel;
    logic [1:0] storecntrl;
    logic [2:0] loadcntrl;
    logic [2:0] cmpcntrl;
    logic [5:0] branch;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       alusrc;
    logic       compare;
    logic       auipc;
    logic       lui;
    logic       jal;
    logic       jalr;
    logic       mul_inst;
    logic       div_inst;
    logic       sys_inst;
  } ctrl_t;

  function automatic logic [3:0] alu_of(
    input logic [2:0] f3,
    input logic       alt
  );
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I(+M, +SYSTEM) instruction decoder.
// Illegal words decode to an all-zero bundle plus a trap cause.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit M_EXT  = 1'b1,
  parameter bit SYS_EN = 1'b0
) (
  input  logic [31:0] ins,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic [1:0]  cause,
  output logic        is_md,
  output logic        lat_sel,
  output logic        bubble
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  ctrl_t      c;

  assign op     = ins[6:0];
  assign f3     = ins[14:12];
  assign f7     = ins[31:25];
  assign bubble = (ins == 32'h0);

  always_comb begin
    c       = '0;
    cause   = CAUSE_NONE;
    is_md   = 1'b0;
    lat_sel = 1'b0;
    unique case (1'b1)
      (op == OP_LUI): begin
        c.regwrite = 1'b1;
        c.lui      = 1'b1;
        c.alusrc   = 1'b1;
        c.alusel   = ALU_PASSB;
      end
      (op == OP_AUIPC): begin
        c.regwrite = 1'b1;
        c.auipc    = 1'b1;
        c.alusrc   = 1'b1;
      end
      (op == OP_JAL): begin
        c.regwrite = 1'b1;
        c.jal      = 1'b1;
      end
      (op == OP_JALR): begin
        c.regwrite = 1'b1;
        c.jalr     = 1'b1;
        c.alusrc   = 1'b1;
        if (f3 != 3'd0) cause = CAUSE_FUNCT;
      end
      (op == OP_BRANCH): begin
        c.compare = 1'b1;
        case (f3)
          3'd0: begin c.cmpcntrl = CMP_EQ;  c.branch = 6'b000001; end
          3'd1: begin c.cmpcntrl = CMP_NE;  c.branch = 6'b000010; end
          3'd4: begin c.cmpcntrl = CMP_LT;  c.branch = 6'b000100; end
          3'd5: begin c.cmpcntrl = CMP_GE;  c.branch = 6'b001000; end
          3'd6: begin c.cmpcntrl = CMP_LTU; c.branch = 6'b010000; end
          3'd7: begin c.cmpcntrl = CMP_GEU; c.branch = 6'b100000; end
          default: cause = CAUSE_FUNCT;
        endcase
      end
      (op == OP_LOAD): begin
        c.memread  = 1'b1;
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        case (f3)
          3'd0:    c.loadcntrl = 3'd1;
          3'd1:    c.loadcntrl = 3'd2;
          3'd2:    c.loadcntrl = 3'd3;
          3'd4:    c.loadcntrl = 3'd4;
          3'd5:    c.loadcntrl = 3'd5;
          default: cause = CAUSE_FUNCT;
        endcase
      end
      (op == OP_STORE): begin
        c.memwrite = 1'b1;
        c.alusrc   = 1'b1;
        if (f3 > 3'd2) cause = CAUSE_FUNCT;
        else c.storecntrl = f3[1:0] + 2'd1;
      end
      (op == OP_IMM): begin
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.alusel   = alu_of(f3, f7[5]);
        if (f3 == 3'd1 && f7 != 7'h00) cause = CAUSE_FUNCT;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)
          cause = CAUSE_FUNCT;
      end
      (op == OP_REG): begin
        c.regwrite = 1'b1;
        if (f7 == 7'h00) begin
          c.alusel = alu_of(f3, 1'b0);
        end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
          c.alusel = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
        end else if (f7 == 7'h01) begin
          // M-extension disabled is its own cause, not a bad funct
          if (!M_EXT) cause = CAUSE_DIS;
          else if (!f3[2]) begin
            c.mul_inst = 1'b1;
            c.mulsel   = {1'b0, f3[1:0]} + 3'd1;
            is_md      = 1'b1;
          end else begin
            c.div_inst = 1'b1;
            c.divsel   = {1'b0, f3[1:0]} + 3'd1;
            is_md      = 1'b1;
            lat_sel    = 1'b1;
          end
        end else begin
          cause = CAUSE_FUNCT;
        end
      end
      (op == OP_FENCE): begin
        c = '0;
      end
      (op == OP_SYSTEM): begin
        if (!SYS_EN) cause = CAUSE_DIS;
        else begin
          c.sys_inst = 1'b1;
          c.regwrite = (f3 != 3'd0);
        end
      end
      default: cause = CAUSE_OPC;
    endcase
    if (bubble) cause = CAUSE_NONE;
    illegal = (cause != CAUSE_NONE);
    ctrl    = illegal ? '0 : c;
  end

endmodule

// File: rtl/decode_ctrl_seq.sv
// Registered decode/control stage: handshake, mul/div latency
// sequencing, stall generation and sticky illegal-instruction trap.
module decode_ctrl_seq
  import ctrl_pkg::*;
#(
  parameter bit M_EXT   = 1'b1,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter bit SYS_EN  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ins,
  input  logic        ins_valid,
  output logic        ins_ready,
  input  logic        flush,
  input  logic        hazard,
  input  logic        ex_ready,
  output logic        ctrl_valid,
  output ctrl_t       ctrl,
  output logic        illegal_ins,
  output logic [1:0]  trap_cause,
  output logic        busy,
  output logic        md_done
);

  localparam logic [4:0] MUL_CNT = 5'(MUL_LAT - 1);
  localparam logic [4:0] DIV_CNT = 5'(DIV_LAT - 1);

  ctrl_t      dec;
  logic       dec_ill;
  logic [1:0] dec_cause;
  logic       dec_md;
  logic       dec_div;
  logic       dec_bub;
  state_t     state;
  logic [4:0] cnt;
  logic       accept;

  ctrl_decode #(
    .M_EXT  (M_EXT),
    .SYS_EN (SYS_EN)
  ) u_dec (
    .ins     (ins),
    .ctrl    (dec),
    .illegal (dec_ill),
    .cause   (dec_cause),
    .is_md   (dec_md),
    .lat_sel (dec_div),
    .bubble  (dec_bub)
  );

  assign busy      = (state == MD_BUSY);
  assign md_done   = busy && (cnt == 5'd0);
  assign ins_ready = (state == IDLE) && !hazard && !flush &&
                     (!ctrl_valid || ex_ready);
  assign accept    = ins_valid && ins_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      ctrl        <= '0;
      ctrl_valid  <= 1'b0;
      illegal_ins <= 1'b0;
      trap_cause  <= CAUSE_NONE;
    end else if (flush) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      ctrl        <= '0;
      ctrl_valid  <= 1'b0;
      illegal_ins <= 1'b0;
      trap_cause  <= CAUSE_NONE;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            ctrl       <= dec;
            ctrl_valid <= !dec_bub;
            if (dec_ill) begin
              illegal_ins <= 1'b1;
              trap_cause  <= dec_cause;
              state       <= TRAP;
            end else if (dec_md) begin
              cnt   <= dec_div ? DIV_CNT : MUL_CNT;
              state <= MD_BUSY;
            end
          end else if (ex_ready) begin
            ctrl_valid <= 1'b0;
          end
        end
        MD_BUSY: begin
          if (cnt != 5'd0) begin
            cnt <= cnt - 5'd1;
          end else if (ex_ready) begin
            state      <= IDLE;
            ctrl_valid <= 1'b0;
          end
        end
        TRAP:    state <= TRAP;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_ctrl_seq.sv
// Bench for decode_ctrl_seq: directed scenarios plus a randomized run
// against an instruction-kind level reference model.
module tb_decode_ctrl_seq;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ins = '0;
  logic        ins_valid = 1'b0;
  logic        flush = 1'b0;
  logic        hazard = 1'b0;
  logic        ex_ready = 1'b0;

  logic        ins_ready, ctrl_valid, illegal_ins, busy, md_done;
  logic [1:0]  trap_cause;
  ctrl_t       ctrl;

  logic        nm_ready, nm_valid, nm_ill, nm_busy, nm_done;
  logic [1:0]  nm_cause;
  ctrl_t       nm_ctrl;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] SUBI = 32'h402081B3;
  localparam logic [31:0] MUL  = 32'h022081B3;
  localparam logic [31:0] DIV  = 32'h0220C1B3;

  always #5 clk = ~clk;

  decode_ctrl_seq dut (
    .clk(clk), .rst_n(rst_n), .ins(ins), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .flush(flush), .hazard(hazard),
    .ex_ready(ex_ready), .ctrl_valid(ctrl_valid), .ctrl(ctrl),
    .illegal_ins(illegal_ins), .trap_cause(trap_cause),
    .busy(busy), .md_done(md_done)
  );

  decode_ctrl_seq #(.M_EXT(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .ins(ins), .ins_valid(ins_valid),
    .ins_ready(nm_ready), .flush(flush), .hazard(hazard),
    .ex_ready(ex_ready), .ctrl_valid(nm_valid), .ctrl(nm_ctrl),
    .illegal_ins(nm_ill), .trap_cause(nm_cause),
    .busy(nm_busy), .md_done(nm_done)
  );

  task automatic do_reset();
    rst_n = 1'b0; ins = '0; ins_valid = 0;
    flush = 0; hazard = 0; ex_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction kinds with the control fields they must produce
  task automatic make_ins(input int k, output logic [31:0] i,
                          output ctrl_t c, output logic [1:0] cs,
                          output int lat, output bit bub);
    logic [4:0] rd, r1, r2;
    logic [11:0] im;
    logic [19:0] u;
    rd = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom);
    im = 12'($urandom); u = 20'($urandom);
    c = '0; cs = 2'b00; lat = 0; bub = 0; i = '0;
    case (k)
      0: begin i = {7'h00, r2, r1, 3'b000, rd, 7'h33}; c.regwrite = 1; end
      1: begin i = {7'h20, r2, r1, 3'b000, rd, 7'h33};
        c.alusel = 4'd1; c.regwrite = 1; end
      2: begin i = {im, r1, 3'b100, rd, 7'h13};
        c.alusel = 4'd5; c.alusrc = 1; c.regwrite = 1; end
      3: begin i = {im, r1, 3'b010, rd, 7'h03};
        c.loadcntrl = 3'd3; c.memread = 1; c.regwrite = 1; c.alusrc = 1; end
      4: begin i = {im[11:5], r2, r1, 3'b010, im[4:0], 7'h23};
        c.storecntrl = 2'd3; c.memwrite = 1; c.alusrc = 1; end
      5: begin i = {im[11:5], r2, r1, 3'b000, im[4:0], 7'h63};
        c.cmpcntrl = 3'd1; c.branch = 6'b000001; c.compare = 1; end
      6: begin i = {im[11:5], r2, r1, 3'b110, im[4:0], 7'h63};
        c.cmpcntrl = 3'd5; c.branch = 6'b010000; c.compare = 1; end
      7: begin i = {u, rd, 7'h6F}; c.regwrite = 1; c.jal = 1; end
      8: begin i = {u, rd, 7'h37};
        c.alusel = 4'd10; c.alusrc = 1; c.regwrite = 1; c.lui = 1; end
      9: begin i = {7'h01, r2, r1, 3'b000, rd, 7'h33};
        c.mulsel = 3'd1; c.mul_inst = 1; c.regwrite = 1; lat = 3; end
      10: begin i = {7'h01, r2, r1, 3'b011, rd, 7'h33};
        c.mulsel = 3'd4; c.mul_inst = 1; c.regwrite = 1; lat = 3; end
      11: begin i = {7'h01, r2, r1, 3'b100, rd, 7'h33};
        c.divsel = 3'd1; c.div_inst = 1; c.regwrite = 1; lat = 8; end
      12: begin i = {7'h01, r2, r1, 3'b111, rd, 7'h33};
        c.divsel = 3'd4; c.div_inst = 1; c.regwrite = 1; lat = 8; end
      13: begin i = $urandom | 32'h7F; cs = 2'b01; end
      14: begin i = {7'h20, r2, r1, 3'b001, rd, 7'h33}; cs = 2'b10; end
      15: begin i = 32'h00000073; cs = 2'b11; end
      default: begin i = 32'h0; bub = 1; end
    endcase
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #13;
    checks++;
    if ({ctrl_valid, illegal_ins, busy, md_done, trap_cause} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000",
               {ctrl_valid, illegal_ins, busy, md_done, trap_cause});
    end
    checks++;
    if (ctrl !== '0) begin
      errors++; $display("FAIL reset_ctrl got %h want 0", ctrl);
    end
    do_reset();
  endtask

  task automatic test_add_b2b();
    do_reset();
    ins = ADD; ins_valid = 1; ex_ready = 1;
    @(negedge clk);
    checks++;
    if (ins_ready !== 1'b1) begin
      errors++; $display("FAIL add_ready got %b want 1", ins_ready);
    end
    tick();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checks++;
      if ({ctrl_valid, ins_ready, ctrl.regwrite} !== 3'b111 ||
          ctrl.alusel !== 4'd0) begin
        errors++;
        $display("FAIL add_b2b[%0d] got v%b r%b w%b alu%h want 1 1 1 0",
                 j, ctrl_valid, ins_ready, ctrl.regwrite, ctrl.alusel);
      end
      tick();
    end
    ins_valid = 0;
  endtask

  task automatic test_mul();
    do_reset();
    ins = MUL; ins_valid = 1; ex_ready = 1;
    tick();
    ins = ADD;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || md_done !== (c == 3) || ins_ready !== 1'b0 ||
          ctrl.mulsel !== 3'd1 || ctrl.mul_inst !== 1'b1) begin
        errors++;
        $display("FAIL mul_cycle%0d got b%b d%b r%b ms%0d want 1 %0d 0 1",
                 c, busy, md_done, ins_ready, ctrl.mulsel, c == 3);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({busy, ins_ready, ctrl_valid} !== 3'b010) begin
      errors++;
      $display("FAIL mul_exit got %b want 010", {busy, ins_ready, ctrl_valid});
    end
    ins_valid = 0;
  endtask

  task automatic test_trap_mdis();
    do_reset();
    ins = DIV; ins_valid = 1; ex_ready = 1;
    tick();
    ins = ADD;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checks++;
      if ({nm_ill, nm_cause, nm_ctrl.regwrite, nm_valid, nm_ready,
           nm_busy, nm_done} !== 8'b11101000) begin
        errors++;
        $display("FAIL mdis_trap got %b want 11101000",
                 {nm_ill, nm_cause, nm_ctrl.regwrite, nm_valid,
                  nm_ready, nm_busy, nm_done});
      end
      tick();
    end
    flush = 1;
    tick();
    flush = 0; ins_valid = 0;
    @(negedge clk);
    checks++;
    if ({nm_ill, nm_cause, nm_valid, nm_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL mdis_flush got %b want 00001",
               {nm_ill, nm_cause, nm_valid, nm_ready});
    end
  endtask

  task automatic test_bad_opcode();
    do_reset();
    ins = 32'hFFFFFFFF; ins_valid = 1; ex_ready = 1;
    tick();
    ins = ADD;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      checks++;
      if ({ins_ready, illegal_ins, trap_cause, ctrl_valid} !== 5'b01011) begin
        errors++;
        $display("FAIL badopc[%0d] got %b want 01011", j,
                 {ins_ready, illegal_ins, trap_cause, ctrl_valid});
      end
      tick();
    end
    flush = 1; ins_valid = 0;
    tick();
    flush = 0;
    @(negedge clk);
    checks++;
    if ({illegal_ins, ctrl_valid, ins_ready} !== 3'b001) begin
      errors++;
      $display("FAIL badopc_flush got %b want 001",
               {illegal_ins, ctrl_valid, ins_ready});
    end
  endtask

  task automatic test_div_flush();
    do_reset();
    ins = DIV; ins_valid = 1; ex_ready = 1;
    tick();
    ins_valid = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || md_done !== 1'b0 || ctrl.divsel !== 3'd1) begin
        errors++;
        $display("FAIL div_cycle%0d got b%b d%b ds%0d want 1 0 1",
                 c, busy, md_done, ctrl.divsel);
      end
      if (c == 4) flush = 1;
      tick();
    end
    flush = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      checks++;
      if ({busy, md_done, ctrl_valid, ins_ready} !== 4'b0001) begin
        errors++;
        $display("FAIL div_flush[%0d] got %b want 0001", j,
                 {busy, md_done, ctrl_valid, ins_ready});
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    ins = ADD; ins_valid = 1; ex_ready = 0;
    tick();
    ins = SUBI;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (ins_ready !== 1'b0 || ctrl_valid !== 1'b1 || ctrl.alusel !== 4'd0) begin
        errors++;
        $display("FAIL stall_hold got r%b v%b alu%h want 0 1 0",
                 ins_ready, ctrl_valid, ctrl.alusel);
      end
      tick();
    end
    ex_ready = 1; hazard = 1;
    @(negedge clk);
    checks++;
    if (ins_ready !== 1'b0) begin
      errors++; $display("FAIL hazard_ready got %b want 0", ins_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({ctrl_valid, ins_ready} !== 2'b00) begin
      errors++;
      $display("FAIL hazard_drain got %b want 00", {ctrl_valid, ins_ready});
    end
    hazard = 0; ins = 32'h0;
    @(negedge clk);
    checks++;
    if (ins_ready !== 1'b1) begin
      errors++; $display("FAIL bubble_ready got %b want 1", ins_ready);
    end
    tick();
    ins_valid = 0;
    @(negedge clk);
    checks++;
    if ({ctrl_valid, busy, illegal_ins} !== 3'b000 || ctrl !== '0) begin
      errors++;
      $display("FAIL bubble got %b ctrl %h want 000 0",
               {ctrl_valid, busy, illegal_ins}, ctrl);
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    ins = MUL; ins_valid = 1; ex_ready = 1;
    tick();
    ins_valid = 0;
    tick();
    #2 rst_n = 0;
    #1;
    checks++;
    if ({busy, md_done, ctrl_valid, illegal_ins, trap_cause} !== 6'b0 ||
        ctrl !== '0) begin
      errors++;
      $display("FAIL reset_busy got %b ctrl %h want 000000 0",
               {busy, md_done, ctrl_valid, illegal_ins, trap_cause}, ctrl);
    end
    #1 rst_n = 1;
  endtask

  task automatic test_random();
    int    mode;
    int    left;
    logic  mvalid, mill;
    logic [1:0] mcause;
    ctrl_t mctrl;
    do_reset();
    mode = 0; left = 0; mvalid = 0; mill = 0; mcause = 0; mctrl = '0;
    for (int n = 0; n < 1500; n++) begin
      int k, lat;
      bit bub;
      logic [31:0] i;
      ctrl_t c;
      logic [1:0] cs;
      logic erdy, acc;
      k = $urandom_range(0, 16);
      make_ins(k, i, c, cs, lat, bub);
      ins = i;
      ins_valid = ($urandom_range(0, 3) != 0);
      hazard = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 11) == 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      erdy = (mode == 0) && !hazard && !flush && (!mvalid || ex_ready);
      @(negedge clk);
      checks++;
      if (ins_ready !== erdy || ctrl_valid !== mvalid ||
          illegal_ins !== mill || trap_cause !== mcause) begin
        errors++;
        $display("FAIL rnd%0d_hs got r%b v%b i%b c%b want r%b v%b i%b c%b",
                 n, ins_ready, ctrl_valid, illegal_ins, trap_cause,
                 erdy, mvalid, mill, mcause);
      end
      checks++;
      if (busy !== (mode == 1) || md_done !== (mode == 1 && left == 1)) begin
        errors++;
        $display("FAIL rnd%0d_md got b%b d%b want b%b d%b", n, busy,
                 md_done, mode == 1, mode == 1 && left == 1);
      end
      checks++;
      if (ctrl !== mctrl) begin
        errors++;
        $display("FAIL rnd%0d_ctrl got %h want %h", n, ctrl, mctrl);
      end
      acc = ins_valid && erdy;
      tick();
      if (flush) begin
        mode = 0; left = 0; mvalid = 0; mill = 0; mcause = 0; mctrl = '0;
      end else if (mode == 0) begin
        if (acc) begin
          mctrl = c;
          mvalid = !bub;
          if (cs != 0) begin
            mill = 1; mcause = cs; mode = 2;
          end else if (lat > 0) begin
            mode = 1; left = lat;
          end
        end else if (ex_ready) mvalid = 0;
      end else if (mode == 1) begin
        if (left > 1) left--;
        else if (ex_ready) begin mode = 0; mvalid = 0; end
      end
    end
    flush = 0; ins_valid = 0; hazard = 0;
  endtask

  initial begin
    test_reset();
    test_add_b2b();
    test_mul();
    test_trap_mdis();
    test_bad_opcode();
    test_div_flush();
    test_stall();
    test_reset_mid_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
